// File: rtl/goldschmidt_round.sv
// Goldschmidt divider finishing stage: overestimate correction,
// rounding, and a small result FIFO behind a valid/ready handshake.
module goldschmidt_round #(
    parameter int WIDTH  = 30,
    parameter int RWIDTH = 24,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           quotient,
    input  logic                       rem_sign,
    input  logic                       rem_zero,
    input  logic [1:0]                 rmode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RWIDTH-1:0]          out_result,
    output logic                       out_inexact,
    output logic                       out_ovf,
    output logic                       out_unf,
    output logic                       overrun,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int G  = WIDTH - RWIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = RWIDTH + 3;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_q;
    logic             s1_sign;
    logic             s1_zero;
    logic [1:0]       s1_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mode  <= 2'b00;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q    <= quotient;
                s1_sign <= rem_sign;
                s1_zero <= rem_zero;
                s1_mode <= rmode;
            end
        end
    end

    logic             exact;
    logic             unf;
    logic [WIDTH-1:0] qc;
    logic [RWIDTH-1:0] t;
    logic [G-1:0]     g;
    logic             half;
    logic             rest;
    logic             inexact;
    logic             inc;
    logic [RWIDTH:0]  sum;
    logic [RWIDTH-1:0] r;
    logic             ovf;

    // An overestimate can never also be exact; treat that pair as inexact.
    assign exact   = s1_zero & ~s1_sign;
    assign unf     = (s1_q == '0) & s1_sign;
    assign qc      = unf ? '0 : s1_q - {{(WIDTH-1){1'b0}}, s1_sign};
    assign t       = qc[WIDTH-1 -: RWIDTH];
    assign g       = qc[G-1:0];
    assign half    = g[G-1];
    assign rest    = (|g[G-2:0]) | ~exact;
    assign inexact = (|g) | ~exact;

    always_comb begin
        inc = 1'b0;
        unique case (1'b1)
            (s1_mode == 2'b01): inc = half & (rest | t[0]);
            (s1_mode == 2'b10): inc = inexact;
            default:            inc = 1'b0;
        endcase
    end

    assign sum = {1'b0, t} + {{RWIDTH{1'b0}}, inc};
    assign ovf = sum[RWIDTH];
    assign r   = ovf ? {RWIDTH{1'b1}} : sum[RWIDTH-1:0];

    logic             s2_valid;
    logic [EW-1:0]    s2_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_entry <= {r, inexact, ovf, unf};
        end
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign full      = (level == DEPTH[AW:0]);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign push      = s2_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (s2_valid & full & ~pop)
                overrun <= 1'b1;
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_result  = head[EW-1:3];
    assign out_inexact = head[2];
    assign out_ovf     = head[1];
    assign out_unf     = head[0];

endmodule

// File: tb/tb_goldschmidt_round.sv
// Directed-vector bench for goldschmidt_round.
module tb_goldschmidt_round;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [29:0] quotient = '0;
    logic        rem_sign = 1'b0;
    logic        rem_zero = 1'b0;
    logic [1:0]  rmode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_result;
    logic        out_inexact;
    logic        out_ovf;
    logic        out_unf;
    logic        overrun;
    logic [1:0]  level;

    int checks = 0;
    int errors = 0;

    goldschmidt_round #(.WIDTH(30), .RWIDTH(24), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .quotient(quotient),
        .rem_sign(rem_sign),
        .rem_zero(rem_zero),
        .rmode(rmode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_inexact(out_inexact),
        .out_ovf(out_ovf),
        .out_unf(out_unf),
        .overrun(overrun),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [29:0] q, input logic rs,
                         input logic rz, input logic [1:0] rm);
        @(negedge clk);
        quotient = q;
        rem_sign = rs;
        rem_zero = rz;
        rmode    = rm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [29:0] q,
                           input logic rs, input logic rz,
                           input logic [1:0] rm, input logic [23:0] er,
                           input logic ex, input logic eo, input logic eu);
        pulse(q, rs, rz, rm);
        @(negedge clk);
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {8'd0, out_result}, {8'd0, er});
        check({tag, "_inx"}, {31'd0, out_inexact}, {31'd0, ex});
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
        check({tag, "_unf"}, {31'd0, out_unf}, {31'd0, eu});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_lvl"}, {30'd0, level}, 32'd0);
    endtask

    initial begin
        int seen;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", {8'd0, out_result}, 32'd0);
        check("rst_flags", {29'd0, out_inexact, out_ovf, out_unf}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_lvl", {30'd0, level}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_one("exact",   30'h0C000000, 1'b0, 1'b1, 2'b01, 24'h300000, 1'b0, 1'b0, 1'b0);
        run_one("corr_rz", 30'h0C000040, 1'b1, 1'b0, 2'b00, 24'h300000, 1'b1, 1'b0, 1'b0);
        run_one("corr_rne",30'h0C000040, 1'b1, 1'b0, 2'b01, 24'h300001, 1'b1, 1'b0, 1'b0);
        run_one("corr_ru", 30'h0C000040, 1'b1, 1'b0, 2'b10, 24'h300001, 1'b1, 1'b0, 1'b0);
        run_one("corr_m11",30'h0C000040, 1'b1, 1'b0, 2'b11, 24'h300000, 1'b1, 1'b0, 1'b0);
        run_one("tie_even",30'h0C000020, 1'b0, 1'b1, 2'b01, 24'h300000, 1'b1, 1'b0, 1'b0);
        run_one("tie_odd", 30'h0C000060, 1'b0, 1'b1, 2'b01, 24'h300002, 1'b1, 1'b0, 1'b0);
        run_one("sat",     30'h3FFFFFFF, 1'b0, 1'b0, 2'b10, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
        run_one("clamp",   30'h00000000, 1'b1, 1'b0, 2'b00, 24'h000000, 1'b1, 1'b0, 1'b1);
        run_one("illegal", 30'h0C000040, 1'b1, 1'b1, 2'b01, 24'h300001, 1'b1, 1'b0, 1'b0);

        pulse(30'h04000000, 1'b0, 1'b1, 2'b00);
        repeat (11) @(negedge clk);
        pulse(30'h08000000, 1'b0, 1'b1, 2'b00);
        repeat (11) @(negedge clk);
        check("bp_lvl2", {30'd0, level}, 32'd2);
        check("bp_ovr0", {31'd0, overrun}, 32'd0);
        pulse(30'h0C000000, 1'b0, 1'b1, 2'b00);
        repeat (3) @(negedge clk);
        check("bp_lvl_full", {30'd0, level}, 32'd2);
        check("bp_ovr1", {31'd0, overrun}, 32'd1);
        check("bp_head0", {8'd0, out_result}, 32'h100000);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head1", {8'd0, out_result}, 32'h200000);
        check("bp_lvl1", {30'd0, level}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_lvl0", {30'd0, level}, 32'd0);
        check("bp_valid0", {31'd0, out_valid}, 32'd0);
        check("bp_ovr_sticky", {31'd0, overrun}, 32'd1);

        pulse(30'h04000000, 1'b0, 1'b1, 2'b00);
        repeat (3) @(negedge clk);
        check("mr_held", {30'd0, level}, 32'd1);
        pulse(30'h08000000, 1'b0, 1'b1, 2'b00);
        reset = 1'b1;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_lvl", {30'd0, level}, 32'd0);
        check("mr_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid)
                seen++;
        end
        check("mr_no_out", seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/goldschmidt_round.md
Name: goldschmidt_round

Overview:
- Downstream finishing stage of the Goldschmidt divider.
- Captures the raw quotient together with the remainder sign/zero flags produced on the divider's remainder cycle.
- Corrects the one-ulp overestimate, rounds to RWIDTH bits under a selectable mode, and flags inexact/overflow/underflow.
- Buffers results in a small FIFO behind a valid/ready handshake. The divider cannot stall, so results that arrive while the FIFO is full are dropped and recorded.

Parameters:
- WIDTH, 30, raw quotient width; fixed point Q2.(WIDTH-2), matching the divider.
- RWIDTH, 24, rounded result width; must satisfy 2 <= RWIDTH <= WIDTH-2. G = WIDTH-RWIDTH guard bits.
- DEPTH, 2, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  one-cycle pulse: quotient/rem_sign/rem_zero are valid
- quotient  input  WIDTH  raw quotient from divider
- rem_sign  input  1  1 = quotient exceeds true quotient by one raw lsb
- rem_zero  input  1  1 = quotient is exact
- rmode  input  2  00 RZ, 01 RNE, 10 RU, 11 treated as RZ; sampled with in_valid
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_result  output  RWIDTH  rounded quotient
- out_inexact  output  1  head result inexact
- out_ovf  output  1  head result saturated high
- out_unf  output  1  head correction clamped at zero
- overrun  output  1  sticky: a result was dropped
- level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): capture stage, round stage, and FIFO pointers are cleared. out_valid=0, out_result=0, all flags=0, overrun=0, level=0.
- Stage 1 (capture): on the edge where in_valid=1, register quotient, rem_sign, rem_zero, rmode, and set s1_valid. When in_valid=0, s1_valid clears. The stage never stalls.
- Stage 2 (round), computed from stage-1 registers and registered with s2_valid:
  - qc = quotient - rem_sign. If quotient==0 and rem_sign=1, then qc=0 and unf=1.
  - t = qc[WIDTH-1 -: RWIDTH]; g = qc[G-1:0]; half = g[G-1]; rest = |g[G-2:0] | ~rem_zero.
  - inexact = |g | ~rem_zero.
  - RZ/11: r = t. RNE: r = t + (half & (rest | t[0])). RU: r = t + inexact.
  - Increment carry-out: r = all ones, ovf=1. inexact is unaffected.
  - rem_sign=1 with rem_zero=1 is illegal. Treat it as rem_sign=1, rem_zero=0.
- FIFO write: when s2_valid=1 and the FIFO is not full (after counting a same-cycle pop), push {r, inexact, ovf, unf}.
- FIFO full: when s2_valid=1, the FIFO is full, and there is no same-cycle pop, the result is dropped. overrun sets and stays set until reset.
- Simultaneous push and pop:
  - Full FIFO: allowed; level is unchanged.
  - Empty FIFO: the pushed entry is not visible the same cycle; no bypass.
- Pop: out_valid & out_ready at an edge. out_* show the head combinationally from storage. Output stays stable while out_valid=1 & out_ready=0.
- Latency: in_valid at edge E0 gives out_valid=1 after edge E2 when the FIFO was empty. Throughput is one result per cycle; the divider delivers at most one per 12 cycles.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Reset mid-operation: in-flight stage-1/stage-2 results and FIFO contents are discarded. No output is emitted for them.

Test Plan:
- Exact result: quotient=30'h0C000000, rem_zero=1, RNE -> out_result=24'h300000, inexact=0, ovf=0, unf=0, out_valid two edges after in_valid.
- Overestimate correction: quotient=30'h0C000040, rem_sign=1:
  - RZ -> 24'h300000, inexact=1.
  - RNE -> 24'h300001.
  - RU -> 24'h300001.
- RNE ties with rem_zero=1: quotient=30'h0C000020 -> 24'h300000; quotient=30'h0C000060 -> 24'h300002; both inexact=1.
- Saturation/clamp:
  - quotient=30'h3FFFFFFF, rem_zero=0, RU -> 24'hFFFFFF, ovf=1.
  - quotient=0, rem_sign=1, RZ -> 0, unf=1, inexact=1.
- Backpressure (DEPTH=2, out_ready=0): three in_valid pulses 12 cycles apart -> level reaches 2, third result dropped, overrun=1. Then raise out_ready -> first two results popped in order, level=0, overrun stays 1.
- Reset mid-flight: assert reset one cycle after in_valid with one FIFO entry held -> out_valid=0, level=0, overrun=0. No result appears after release.
